// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg: shared types for the L1 data cache controller.
//   mem_cmd_e   : RD / WR command encoding (core and L2 side)
//   mem_width_e : BYTE / HWORD / WORD access width (value = log2 bytes)
//   mem_resp_e  : NOTRDY / RDY_OK / RDY_ER core response codes
//   state_e     : controller FSM states
//   calc_wstrb      : byte strobes from width and low address bits
//   replicate_wdata : spreads the low bytes of the write data across all lanes
package l1_cache_pkg;

    typedef enum logic {
        MEM_RD = 1'b0,
        MEM_WR = 1'b1
    } mem_cmd_e;

    typedef enum logic [1:0] {
        MEM_BYTE  = 2'd0,
        MEM_HWORD = 2'd1,
        MEM_WORD  = 2'd2
    } mem_width_e;

    typedef enum logic [1:0] {
        RESP_NOTRDY = 2'd0,
        RESP_RDY_OK = 2'd1,
        RESP_RDY_ER = 2'd2
    } mem_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_WT_REQ  = 3'd2,
        ST_WT_WAIT = 3'd3,
        ST_RF_REQ  = 3'd4,
        ST_RF_DATA = 3'd5,
        ST_RESP    = 3'd6
    } state_e;

    function automatic logic [3:0] calc_wstrb(input logic [1:0] width, input logic [1:0] addr);
        logic [3:0] s;
        case (width)
            MEM_BYTE:  s = 4'b0001 << addr;
            MEM_HWORD: s = addr[1] ? 4'b1100 : 4'b0011;
            default:   s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] replicate_wdata(input logic [1:0] width, input logic [31:0] d);
        logic [31:0] r;
        case (width)
            MEM_BYTE:  r = {4{d[7:0]}};
            MEM_HWORD: r = {2{d[15:0]}};
            default:   r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/l1_cache_way.sv
// l1_cache_way: one way of the cache: valid bits, tags and line data in flops.
// Ports:
//   clk, rst            clock, async active-high reset (clears valid bits only)
//   idx                 set index shared by all read/write operations
//   rd_word             word select for the combinational read
//   rd_valid/rd_tag/rd_data  lookup results for idx
//   wr_en/wr_word/wr_be/wr_data  byte-enabled word write into set idx
//   set_valid/set_tag   mark set idx valid and store its tag
//   clr_valid           mark set idx invalid
module l1_cache_way #(
    parameter int SETS  = 16,
    parameter int LINE_WORDS = 8,
    parameter int IDX_W = 4,
    parameter int WRD_W = 3,
    parameter int TAG_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic [WRD_W-1:0] rd_word,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [WRD_W-1:0] wr_word,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    input  logic             set_valid,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clr_valid
);

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS][LINE_WORDS];

    always_comb begin
        valid_d = valid_q;
        if (clr_valid) valid_d[idx] = 1'b0;
        if (set_valid) valid_d[idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // Tag and data carry no reset; the valid bit guards them.
    always_ff @(posedge clk) begin
        if (set_valid) tag_q[idx] <= set_tag;
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) data_q[idx][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx][rd_word];

endmodule

// File: rtl/l1_dcache_ctrl.sv
// l1_dcache_ctrl: write-through, no-write-allocate L1 data cache controller.
// Ports:
//   clk, rst                 clock, async active-high reset
//   core_req/cmd/width/addr/wdata  core request; core_req_ack accepts (IDLE only)
//   core_rdata, core_resp    read data and one-cycle RDY_OK/RDY_ER response
//   l2_req_*                 L2 request channel (valid/ready handshake)
//   l2_resp_val/err/rdata    L2 write completion or refill beat
// Optional: define L1_DCACHE_STATS_EN to add stat_hits / stat_misses
// (saturating read hit/miss counters, cleared by rst).
module l1_dcache_ctrl
    import l1_cache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_cmd,
    input  logic [1:0]            core_width,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_req_ack,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic [1:0]            core_resp,
    output logic                  l2_req_val,
    input  logic                  l2_req_rdy,
    output logic                  l2_req_cmd,
    output logic [2:0]            l2_req_size,
    output logic [ADDR_WIDTH-1:0] l2_req_addr,
    output logic [DATA_WIDTH-1:0] l2_req_wdata,
    output logic [3:0]            l2_req_wstrb,
    input  logic                  l2_resp_val,
    input  logic                  l2_resp_err,
    input  logic [DATA_WIDTH-1:0] l2_resp_rdata
`ifdef L1_DCACHE_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WRD_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - WRD_W - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_e                  state_q, state_d;
    logic                    cmd_q, cmd_d;
    logic [1:0]              width_q, width_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    hit_q, hit_d;
    logic [WAY_W-1:0]        hit_way_q, hit_way_d;
    logic [WAY_W-1:0]        victim_q, victim_d;
    logic [WRD_W-1:0]        beat_q, beat_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic [WAY_W-1:0]        rr_q [SETS];
    logic [WAY_W-1:0]        rr_d [SETS];

    logic [TAG_W-1:0]        tag_a;
    logic [IDX_W-1:0]        idx_a;
    logic [WRD_W-1:0]        word_a;

    logic [WAYS-1:0]         way_vld, way_we, way_set, way_clr;
    logic [TAG_W-1:0]        way_tag   [WAYS];
    logic [31:0]             way_rdata [WAYS];
    logic [WRD_W-1:0]        wr_word;
    logic [3:0]              wr_be;
    logic [31:0]             wr_data;

    logic                    hit_any, inv_found, misalign, rf_bad;
    logic [WAY_W-1:0]        hit_way, inv_way;

    assign tag_a  = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign idx_a  = addr_q[2+WRD_W +: IDX_W];
    assign word_a = addr_q[2 +: WRD_W];

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        l1_cache_way #(
            .SETS(SETS), .LINE_WORDS(LINE_WORDS),
            .IDX_W(IDX_W), .WRD_W(WRD_W), .TAG_W(TAG_W)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .idx       (idx_a),
            .rd_word   (word_a),
            .rd_valid  (way_vld[g]),
            .rd_tag    (way_tag[g]),
            .rd_data   (way_rdata[g]),
            .wr_en     (way_we[g]),
            .wr_word   (wr_word),
            .wr_be     (wr_be),
            .wr_data   (wr_data),
            .set_valid (way_set[g]),
            .set_tag   (tag_a),
            .clr_valid (way_clr[g])
        );
    end

    // Lowest-index hit and lowest-index invalid way for the latched address.
    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (way_vld[w] && (way_tag[w] == tag_a)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!way_vld[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign misalign = ((width_q == MEM_HWORD) && addr_q[0]) ||
                      ((width_q == MEM_WORD) && (addr_q[1:0] != 2'b00)) ||
                      (width_q == 2'd3);
    assign rf_bad   = err_q || l2_resp_err;

`ifdef L1_DCACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d, stat_misses_q, stat_misses_d;
    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (state_q == ST_LOOKUP && cmd_q == MEM_RD && !misalign) begin
            if (hit_any && stat_hits_q != '1)    stat_hits_d   = stat_hits_q + 32'd1;
            if (!hit_any && stat_misses_q != '1) stat_misses_d = stat_misses_q + 32'd1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end
    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        width_d   = width_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        hit_d     = hit_q;
        hit_way_d = hit_way_q;
        victim_d  = victim_q;
        beat_d    = beat_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        rr_d      = rr_q;
        way_we    = '0;
        way_set   = '0;
        way_clr   = '0;
        wr_word   = word_a;
        wr_be     = calc_wstrb(width_q, addr_q[1:0]);
        wr_data   = replicate_wdata(width_q, wdata_q);
        case (state_q)
            ST_IDLE: begin
                if (core_req && core_req_ack) begin
                    cmd_d   = core_cmd;
                    width_d = core_width;
                    addr_d  = core_addr;
                    wdata_d = core_wdata;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (misalign) begin
                    resp_d  = RESP_RDY_ER;
                    state_d = ST_RESP;
                end else if (cmd_q == MEM_WR) begin
                    hit_d     = hit_any;
                    hit_way_d = hit_way;
                    state_d   = ST_WT_REQ;
                end else if (hit_any) begin
                    rdata_d = way_rdata[hit_way];
                    resp_d  = RESP_RDY_OK;
                    state_d = ST_RESP;
                end else begin
                    // Invalidate the victim up front so an aborted or failed
                    // refill never leaves a half-written line marked valid.
                    victim_d          = inv_found ? inv_way : rr_q[idx_a];
                    way_clr[victim_d] = 1'b1;
                    beat_d            = '0;
                    err_d             = 1'b0;
                    state_d           = ST_RF_REQ;
                end
            end
            ST_WT_REQ: begin
                if (l2_req_rdy) begin
                    // Cache copy follows the write at L2 acceptance, whatever the L2 result.
                    if (hit_q) way_we[hit_way_q] = 1'b1;
                    state_d = ST_WT_WAIT;
                end
            end
            ST_WT_WAIT: begin
                if (l2_resp_val) begin
                    resp_d  = l2_resp_err ? RESP_RDY_ER : RESP_RDY_OK;
                    state_d = ST_RESP;
                end
            end
            ST_RF_REQ: begin
                if (l2_req_rdy) state_d = ST_RF_DATA;
            end
            ST_RF_DATA: begin
                if (l2_resp_val) begin
                    // After an error the remaining beats are counted but dropped.
                    if (!rf_bad) begin
                        way_we[victim_q] = 1'b1;
                        wr_word          = beat_q;
                        wr_be            = 4'b1111;
                        wr_data          = l2_resp_rdata;
                        if (beat_q == word_a) rdata_d = l2_resp_rdata;
                    end
                    err_d  = rf_bad;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == WRD_W'(LINE_WORDS-1)) begin
                        if (!rf_bad) way_set[victim_q] = 1'b1;
                        rr_d[idx_a] = (rr_q[idx_a] == WAY_W'(WAYS-1)) ? '0 : rr_q[idx_a] + 1'b1;
                        resp_d      = rf_bad ? RESP_RDY_ER : RESP_RDY_OK;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            resp_q  <= RESP_NOTRDY;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        cmd_q     <= cmd_d;
        width_q   <= width_d;
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        hit_q     <= hit_d;
        hit_way_q <= hit_way_d;
        victim_q  <= victim_d;
    end

    assign core_req_ack = (state_q == ST_IDLE) && !rst;
    assign core_resp    = (state_q == ST_RESP) ? resp_q : RESP_NOTRDY;
    assign core_rdata   = rdata_q;

    always_comb begin
        l2_req_val   = 1'b0;
        l2_req_cmd   = MEM_RD;
        l2_req_size  = 3'd0;
        l2_req_addr  = '0;
        l2_req_wdata = '0;
        l2_req_wstrb = 4'b0000;
        if (state_q == ST_WT_REQ) begin
            l2_req_val   = 1'b1;
            l2_req_cmd   = MEM_WR;
            l2_req_size  = {1'b0, width_q};
            l2_req_addr  = addr_q;
            l2_req_wdata = replicate_wdata(width_q, wdata_q);
            l2_req_wstrb = calc_wstrb(width_q, addr_q[1:0]);
        end else if (state_q == ST_RF_REQ) begin
            l2_req_val  = 1'b1;
            l2_req_size = 3'(2 + WRD_W);
            l2_req_addr = {addr_q[ADDR_WIDTH-1:2+WRD_W], {(WRD_W+2){1'b0}}};
        end
    end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
module tb_l1_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_cmd;
    logic [1:0]  core_width;
    logic [15:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_req_ack;
    logic [31:0] core_rdata;
    logic [1:0]  core_resp;
    logic        l2_req_val, l2_req_rdy, l2_req_cmd;
    logic [2:0]  l2_req_size;
    logic [15:0] l2_req_addr;
    logic [31:0] l2_req_wdata;
    logic [3:0]  l2_req_wstrb;
    logic        l2_resp_val, l2_resp_err;
    logic [31:0] l2_resp_rdata;
`ifdef L1_DCACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    always #5 clk = ~clk;

    l1_dcache_ctrl dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_cmd(core_cmd), .core_width(core_width),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_req_ack(core_req_ack), .core_rdata(core_rdata), .core_resp(core_resp),
        .l2_req_val(l2_req_val), .l2_req_rdy(l2_req_rdy), .l2_req_cmd(l2_req_cmd),
        .l2_req_size(l2_req_size), .l2_req_addr(l2_req_addr),
        .l2_req_wdata(l2_req_wdata), .l2_req_wstrb(l2_req_wstrb),
        .l2_resp_val(l2_resp_val), .l2_resp_err(l2_resp_err), .l2_resp_rdata(l2_resp_rdata)
`ifdef L1_DCACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    typedef struct {
        logic        cmd;
        logic [1:0]  width;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          err_beat;   // refill beat carrying l2_resp_err; for writes >=0 means error
        logic [1:0]  resp;
        bit          chk_rdata;
        logic [31:0] rdata;
        bit          l2;
        logic [15:0] l2addr;
        logic [2:0]  l2size;
        logic [3:0]  l2strb;
        int          lat;        // 0 = latency not checked
    } vec_t;

    vec_t vec [21];
    int   nvec = 0;
    int   checks = 0;
    int   errors = 0;

    // Captured results of one transaction
    logic [1:0]  r_resp;
    logic [31:0] r_rdata;
    int          r_lat, r_l2cnt, r_beats;
    logic        r_l2cmd;
    logic [15:0] r_l2addr;
    logic [2:0]  r_l2size;
    logic [3:0]  r_l2strb;
    logic [31:0] r_l2wdata;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {16'hC0DE, a[15:2], 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic cmd, input logic [1:0] w, input logic [15:0] a, input logic [31:0] wd,
                       input int eb, input logic [1:0] rs, input bit cr, input logic [31:0] rd,
                       input bit l2, input logic [15:0] la, input logic [2:0] ls, input logic [3:0] lw,
                       input int lat);
        vec[nvec] = '{cmd, w, a, wd, eb, rs, cr, rd, l2, la, ls, lw, lat};
        nvec++;
    endtask

    // Drives one core request and plays the L2 side until the core response.
    task automatic run_txn(input int k);
        int  t, ack_t, req_cnt;
        bit  refill, wwait, got, ack_now;
        core_cmd   = vec[k].cmd;
        core_width = vec[k].width;
        core_addr  = vec[k].addr;
        core_wdata = vec[k].wdata;
        core_req   = 1'b1;
        t = 0; ack_t = 0; req_cnt = 0; refill = 0; wwait = 0; got = 0;
        r_l2cnt = 0; r_beats = 0; r_l2addr = '0; r_l2size = '0; r_l2strb = '0;
        r_l2wdata = '0; r_l2cmd = 1'b0; r_resp = 2'd0; r_rdata = '0; r_lat = 0;
        while (!got && t < 100) begin
            if (core_resp != 2'd0) begin
                got     = 1;
                r_resp  = core_resp;
                r_rdata = core_rdata;
                r_lat   = t - ack_t;
            end else begin
                l2_req_rdy = 0; l2_resp_val = 0; l2_resp_err = 0; l2_resp_rdata = '0;
                if (l2_req_val) begin
                    if (req_cnt == 0) begin
                        r_l2cmd = l2_req_cmd; r_l2addr = l2_req_addr; r_l2size = l2_req_size;
                        r_l2strb = l2_req_wstrb; r_l2wdata = l2_req_wdata;
                    end
                    req_cnt++;
                    // hold off ready one cycle so the request must stay up
                    if (req_cnt >= 2) begin
                        l2_req_rdy = 1;
                        r_l2cnt++;
                        req_cnt = 0;
                        if (l2_req_cmd == 1'b0) refill = 1; else wwait = 1;
                    end
                end else if (refill && r_beats < 8) begin
                    l2_resp_val   = 1;
                    l2_resp_rdata = mem_word(r_l2addr + 16'(4 * r_beats));
                    l2_resp_err   = (r_beats == vec[k].err_beat);
                    r_beats++;
                end else if (wwait) begin
                    l2_resp_val = 1;
                    l2_resp_err = (vec[k].err_beat >= 0);
                    wwait = 0;
                end
                ack_now = core_req && core_req_ack;
                if (ack_now) ack_t = t;
                @(posedge clk); #1;
                t++;
                if (ack_now) core_req = 0;
            end
        end
        l2_req_rdy = 0; l2_resp_val = 0; l2_resp_err = 0;
        core_req = 0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL txn%0d_timeout no core response within 100 cycles", k);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_txn(input int k);
        chk($sformatf("v%0d_resp", k), 32'(r_resp), 32'(vec[k].resp));
        if (vec[k].chk_rdata) chk($sformatf("v%0d_rdata", k), r_rdata, vec[k].rdata);
        chk($sformatf("v%0d_l2_count", k), 32'(r_l2cnt), vec[k].l2 ? 32'd1 : 32'd0);
        if (vec[k].l2) begin
            chk($sformatf("v%0d_l2_cmd", k), 32'(r_l2cmd), 32'(vec[k].cmd));
            chk($sformatf("v%0d_l2_addr", k), 32'(r_l2addr), 32'(vec[k].l2addr));
            chk($sformatf("v%0d_l2_size", k), 32'(r_l2size), 32'(vec[k].l2size));
            if (vec[k].cmd) begin
                chk($sformatf("v%0d_l2_wstrb", k), 32'(r_l2strb), 32'(vec[k].l2strb));
                chk($sformatf("v%0d_l2_wdata", k), r_l2wdata, vec[k].wdata);
            end else begin
                chk($sformatf("v%0d_beats", k), 32'(r_beats), 32'd8);
            end
        end
        if (vec[k].lat != 0) chk($sformatf("v%0d_latency", k), 32'(r_lat), 32'(vec[k].lat));
    endtask

    initial begin
        //  cmd  w     addr      wdata         err  resp  chk rdata          l2 l2addr   sz    strb     lat
        add(1'b0, 2'd2, 16'h0040, 32'h0,        -1, 2'd1, 1, 32'hC0DE0040, 1, 16'h0040, 3'd5, 4'b0000, 0);
        add(1'b0, 2'd2, 16'h0040, 32'h0,        -1, 2'd1, 1, 32'hC0DE0040, 0, 16'h0,    3'd0, 4'b0000, 2);
        add(1'b0, 2'd2, 16'h0048, 32'h0,        -1, 2'd1, 1, 32'hC0DE0048, 0, 16'h0,    3'd0, 4'b0000, 2);
        add(1'b0, 2'd2, 16'h0240, 32'h0,        -1, 2'd1, 1, 32'hC0DE0240, 1, 16'h0240, 3'd5, 4'b0000, 0);
        add(1'b0, 2'd2, 16'h0440, 32'h0,        -1, 2'd1, 1, 32'hC0DE0440, 1, 16'h0440, 3'd5, 4'b0000, 0);
        add(1'b0, 2'd2, 16'h0240, 32'h0,        -1, 2'd1, 1, 32'hC0DE0240, 0, 16'h0,    3'd0, 4'b0000, 2);
        add(1'b0, 2'd2, 16'h0040, 32'h0,        -1, 2'd1, 1, 32'hC0DE0040, 1, 16'h0040, 3'd5, 4'b0000, 0);
        add(1'b1, 2'd0, 16'h0043, 32'hABABABAB, -1, 2'd1, 0, 32'h0,        1, 16'h0043, 3'd0, 4'b1000, 0);
        add(1'b0, 2'd2, 16'h0040, 32'h0,        -1, 2'd1, 1, 32'hABDE0040, 0, 16'h0,    3'd0, 4'b0000, 2);
        add(1'b0, 2'd1, 16'h0041, 32'h0,        -1, 2'd2, 0, 32'h0,        0, 16'h0,    3'd0, 4'b0000, 2);
        add(1'b0, 2'd2, 16'h0042, 32'h0,        -1, 2'd2, 0, 32'h0,        0, 16'h0,    3'd0, 4'b0000, 2);
        add(1'b0, 2'd1, 16'h0042, 32'h0,        -1, 2'd1, 1, 32'hABDE0040, 0, 16'h0,    3'd0, 4'b0000, 2);
        add(1'b1, 2'd2, 16'h0044, 32'h11223344,  0, 2'd2, 0, 32'h0,        1, 16'h0044, 3'd2, 4'b1111, 0);
        add(1'b0, 2'd2, 16'h0044, 32'h0,        -1, 2'd1, 1, 32'h11223344, 0, 16'h0,    3'd0, 4'b0000, 2);
        add(1'b1, 2'd1, 16'h1002, 32'h55665566, -1, 2'd1, 0, 32'h0,        1, 16'h1002, 3'd1, 4'b1100, 0);
        add(1'b0, 2'd2, 16'h1000, 32'h0,        -1, 2'd1, 1, 32'hC0DE1000, 1, 16'h1000, 3'd5, 4'b0000, 0);
        add(1'b0, 2'd2, 16'h0C4C, 32'h0,         3, 2'd2, 0, 32'h0,        1, 16'h0C40, 3'd5, 4'b0000, 0);
        add(1'b0, 2'd2, 16'h0C4C, 32'h0,        -1, 2'd1, 1, 32'hC0DE0C4C, 1, 16'h0C40, 3'd5, 4'b0000, 0);
        add(1'b0, 2'd2, 16'h0040, 32'h0,        -1, 2'd1, 1, 32'hABDE0040, 0, 16'h0,    3'd0, 4'b0000, 2);
        // after the mid-refill reset
        add(1'b0, 2'd2, 16'h0840, 32'h0,        -1, 2'd1, 1, 32'hC0DE0840, 1, 16'h0840, 3'd5, 4'b0000, 0);
        add(1'b0, 2'd2, 16'h0040, 32'h0,        -1, 2'd1, 1, 32'hC0DE0040, 1, 16'h0040, 3'd5, 4'b0000, 0);

        rst = 1; core_req = 0; core_cmd = 0; core_width = 0; core_addr = 0; core_wdata = 0;
        l2_req_rdy = 0; l2_resp_val = 0; l2_resp_err = 0; l2_resp_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(core_req_ack), 32'd0);
        chk("rst_resp", 32'(core_resp), 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        chk("rst_l2_val", 32'(l2_req_val), 32'd0);
        rst = 0;
        @(posedge clk); #1;
        chk("idle_ack", 32'(core_req_ack), 32'd1);

        for (int k = 0; k < 19; k++) begin
            run_txn(k);
            check_txn(k);
        end

        // Reset in the middle of a refill of 0x0840
        core_cmd = 0; core_width = 2'd2; core_addr = 16'h0840; core_req = 1;
        @(posedge clk); #1;
        core_req = 0;
        @(posedge clk); #1;
        chk("mid_rf_l2_val", 32'(l2_req_val), 32'd1);
        l2_req_rdy = 1;
        @(posedge clk); #1;
        l2_req_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            l2_resp_val = 1; l2_resp_rdata = mem_word(16'h0840 + 16'(4 * i));
            @(posedge clk); #1;
        end
        l2_resp_val = 0;
        rst = 1;
        #1;
        chk("mid_rst_ack", 32'(core_req_ack), 32'd0);
        chk("mid_rst_resp", 32'(core_resp), 32'd0);
        chk("mid_rst_rdata", core_rdata, 32'd0);
        chk("mid_rst_l2_val", 32'(l2_req_val), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            l2_resp_val = 1; l2_resp_rdata = 32'hDEADBEEF;
            @(posedge clk); #1;
            chk($sformatf("stray_beat%0d_resp", i), 32'(core_resp), 32'd0);
            chk($sformatf("stray_beat%0d_l2_val", i), 32'(l2_req_val), 32'd0);
        end
        l2_resp_val = 0;
        chk("post_rst_ack", 32'(core_req_ack), 32'd1);

        for (int k = 19; k < 21; k++) begin
            run_txn(k);
            check_txn(k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
